// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the serial programmable FIR.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  // Width used by round_sat; accumulators are sign-extended into it.
  localparam int RS_W = 64;

  // Accumulator width that cannot overflow over TAPS full-scale products.
  function automatic int calc_acc_w(input int din_w, input int coef_w, input int taps);
    return din_w + coef_w + $clog2(taps);
  endfunction

  // Round half toward +inf by 2^frac, then clamp to a dout_w-bit signed range.
  function automatic logic signed [RS_W-1:0] round_sat(
    input logic signed [RS_W-1:0] acc,
    input int                     frac,
    input int                     dout_w
  );
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    if (frac > 0) begin
      r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    end else begin
      r = acc;
    end
    hi = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dout_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient banks. The shadow bank is written at any time;
// the active bank is reloaded from it only on commit, so a running MAC
// pass always sees a stable coefficient set. Tap k lives at
// COEF_INIT[k*COEF_W +: COEF_W].
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int                      COEF_W    = 8,
  parameter int                      TAPS      = 16,
  parameter logic [TAPS*COEF_W-1:0]  COEF_INIT = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic [$clog2(TAPS)-1:0]    addr_i,
  input  logic signed [COEF_W-1:0]   wdata_i,
  input  logic                       commit_i,
  input  logic [$clog2(TAPS)-1:0]    rd_idx_i,
  output logic signed [COEF_W-1:0]   rd_coef_o
);

  localparam int          AW     = $clog2(TAPS);
  localparam int unsigned NADDR  = 2 ** AW;
  localparam int unsigned NTAPS  = TAPS;

  logic signed [COEF_W-1:0] shadow_q [TAPS];
  logic signed [COEF_W-1:0] shadow_d [TAPS];
  logic signed [COEF_W-1:0] active_q [TAPS];
  logic [NADDR-1:0]         addr_ok;

  // Addresses at or beyond TAPS map to nothing and are dropped.
  always_comb begin
    addr_ok = '0;
    for (int unsigned i = 0; i < NADDR; i++) begin
      addr_ok[i] = (i < NTAPS);
    end
  end

  // Next shadow contents; a same-cycle write is visible to a commit.
  always_comb begin
    shadow_d = shadow_q;
    if (we_i && addr_ok[addr_i]) begin
      shadow_d[addr_i] = wdata_i;
    end
  end

  // Bank registers: reset to COEF_INIT, commit copies the updated shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        shadow_q[i] <= COEF_INIT[i*COEF_W +: COEF_W];
        active_q[i] <= COEF_INIT[i*COEF_W +: COEF_W];
      end
    end else begin
      shadow_q <= shadow_d;
      if (commit_i) begin
        active_q <= shadow_d;
      end
    end
  end

  // Combinational read of the active coefficient for the current tap.
  always_comb begin
    rd_coef_o = active_q[rd_idx_i];
  end

endmodule

// File: rtl/fir_serial_prog.sv
// Single-MAC time-multiplexed FIR with programmable coefficients,
// valid/ready input handshake and round-then-saturate output.
module fir_serial_prog
  import fir_pkg::*;
#(
  parameter int                      DIN_W     = 10,
  parameter int                      DOUT_W    = 11,
  parameter int                      COEF_W    = 8,
  parameter int                      TAPS      = 16,
  parameter int                      FRAC      = 6,
  parameter logic [TAPS*COEF_W-1:0]  COEF_INIT = {
    8'h00, 8'h00, 8'h01, 8'hFE, 8'h02, 8'h00, 8'hF9, 8'h26,
    8'h26, 8'hF9, 8'h00, 8'h02, 8'hFE, 8'h01, 8'h00, 8'h00
  }
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [DIN_W-1:0]    din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic signed [DOUT_W-1:0]   dout,
  output logic                       dout_valid,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DIN_W + COEF_W;
  localparam int ACC_W  = calc_acc_w(DIN_W, COEF_W, TAPS);

  state_e                    state_q, state_d;
  logic signed [DIN_W-1:0]   x_q [TAPS];
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]             k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DOUT_W-1:0]  dout_q, dout_d;

  logic                      accept;
  logic                      last_tap;
  logic signed [COEF_W-1:0]  coef_rd;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   mac_sum;

  fir_coef_bank #(
    .COEF_W    (COEF_W),
    .TAPS      (TAPS),
    .COEF_INIT (COEF_INIT)
  ) u_coef_bank (
    .clk       (clk),
    .rst       (rst),
    .we_i      (coef_we),
    .addr_i    (coef_addr),
    .wdata_i   (coef_wdata),
    .commit_i  (accept),
    .rd_idx_i  (k_q),
    .rd_coef_o (coef_rd)
  );

  // Handshake and MAC step decode.
  always_comb begin
    accept   = din_valid && din_ready;
    last_tap = (k_q == AW'(TAPS - 1));
    prod     = PROD_W'(coef_rd) * PROD_W'(x_q[rd_ptr_q]);
    mac_sum  = acc_q + ACC_W'(prod);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = MAC;
      MAC:     if (last_tap) state_d = OUT;
      OUT:                   state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    din_ready  = (state_q == IDLE);
    dout_valid = (state_q == OUT);
    dout       = dout_q;
  end

  // Datapath next state: pointers, tap counter, accumulator, output.
  // dout is loaded from the final sum on the last MAC edge so that it is
  // already new during the single OUT cycle that flags it.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    k_d      = k_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_ptr_d = (wr_ptr_q == AW'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
          rd_ptr_d = wr_ptr_q;
          k_d      = '0;
          acc_d    = '0;
        end
      end
      MAC: begin
        acc_d    = mac_sum;
        k_d      = k_q + 1'b1;
        rd_ptr_d = (rd_ptr_q == '0) ? AW'(TAPS - 1) : rd_ptr_q - 1'b1;
        if (last_tap) begin
          dout_d = DOUT_W'(round_sat(RS_W'(mac_sum), FRAC, DOUT_W));
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
    end
  end

  // Circular delay line, written only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
    end else if (accept) begin
      x_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: doc/fir_serial_prog.md
Name: fir_serial_prog

Overview:
- Programmable-coefficient, single-MAC (time-multiplexed) FIR filter; successor to the fixed-coefficient, fully parallel fir_sync.
- Generalised in input width, output width, coefficient width and tap count.
- Adds a valid/ready input handshake, runtime coefficient reload through a shadow bank, and round-then-saturate output scaling.
- Sits between the sample source and downstream DSP in the same clock domain.

Parameters:
- DIN_W, 10, signed input sample width.
- DOUT_W, 11, signed output width.
- COEF_W, 8, signed coefficient width.
- TAPS, 16, number of taps; must be at least 2.
- FRAC, 6, right shift applied to the accumulator before output; 0 means no rounding.
- COEF_INIT, {0,0,1,-2,2,0,-7,38,38,-7,0,2,-2,1,0,0}, packed TAPS×COEF_W reset coefficients, tap 0 first.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- din  in  DIN_W  signed sample.
- din_valid  in  1  din is presented.
- din_ready  out  1  block can accept a sample.
- dout  out  DOUT_W  signed filtered result.
- dout_valid  out  1  one-cycle strobe: dout is new.
- coef_we  in  1  shadow coefficient write enable.
- coef_addr  in  clog2(TAPS)  tap index; values of TAPS or above are ignored.
- coef_wdata  in  COEF_W  signed coefficient value.

Behaviour:
- Reset (rst high at a clock edge):
  - State = IDLE; din_ready=1, dout=0, dout_valid=0.
  - Delay line cleared to 0.
  - Active and shadow banks loaded from COEF_INIT.
  - Takes priority over every other input. An in-flight MAC is abandoned and no dout_valid is produced.
- IDLE:
  - din_ready=1.
  - Accept occurs when din_valid && din_ready at an edge. On accept:
    - din is written to the circular delay line at wr_ptr.
    - wr_ptr advances modulo TAPS (wrap TAPS-1 -> 0).
    - The shadow bank is copied to the active bank. A coef_we in the same cycle is included in the copy.
    - acc=0, k=0; go to MAC.
- MAC, TAPS cycles:
  - din_ready=0.
  - Each cycle: acc += coef_active[k] * x[n-k], where x[n] is the newest sample and k runs 0..TAPS-1.
  - On k=TAPS-1, go to OUT.
- OUT, 1 cycle:
  - dout <= sat(round(acc)).
  - dout_valid=1 for exactly this cycle.
  - din_ready=0; next state IDLE.
- Timing:
  - Sample accepted at edge T gives dout_valid high during cycle T+TAPS+1.
  - Maximum throughput is one sample per TAPS+2 cycles.
  - dout holds its value until the next OUT.
- Arithmetic:
  - ACC_W = DIN_W+COEF_W+clog2(TAPS), signed, no internal overflow possible.
  - round: if FRAC>0, (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half toward +inf; if FRAC=0, acc unchanged.
  - sat: clamp to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
- Coefficient writes:
  - coef_we writes shadow[coef_addr] in any state.
  - Coefficients in use during MAC are never modified; a new coefficient set takes effect only at the next accept.
  - Writes with out-of-range coef_addr are dropped.
- Other boundaries:
  - din_valid while din_ready=0: sample is not consumed; the source holds it.
  - Default COEF_INIT sums to 64, so FRAC=6 gives unity DC gain.

Decomposition:
- Package fir_pkg holds:
  - the ACC_W computation function;
  - the round_sat function (acc, FRAC, DOUT_W);
  - the state enum IDLE/MAC/OUT.
- Sub-module fir_coef_bank holds the shadow and active register banks, the write port, the commit strobe and a combinational read at index k.
- Delay line, pointer, FSM and MAC stay in the top level.

Test Plan:
- Impulse: default coefficients, FRAC=6, one sample 100 then zeros.
  - Successive dout (taps 0..15): 0,0,2,-3,3,0,-11,59,59,-11,0,3,-3,2,0,0.
  - Each dout_valid arrives exactly TAPS+1=17 cycles after its accept.
- DC step: din=500 held with din_valid=1.
  - After 16 outputs, dout is a steady 500.
  - din_ready is low for 17 of every 18 cycles.
- Saturation: write all shadow coefficients = 127.
  - din=511 constant: dout saturates at 1023.
  - din=-512 constant: dout saturates at -1024.
- Coefficient commit: write coef[7]=0 during a MAC run.
  - The in-flight output is unchanged.
  - The next output reflects the new value; an impulse of 100 gives 0 at tap 7.
- Mid-MAC reset: assert rst at MAC cycle 5.
  - No dout_valid is produced; dout=0; din_ready=1 on the next cycle.
  - Coefficients return to COEF_INIT; the next impulse reproduces scenario 1.
- Handshake/wrap:
  - Random din_valid gaps over 100 samples; outputs match a golden model.
  - wr_ptr wraps 15 -> 0 correctly.
  - An out-of-range coef_addr write has no effect.
